// File: rtl/roach_reset_sequencer.sv
// roach_reset_sequencer
// Power-up and recovery reset sequencer that sits after the ROACH clock
// infrastructure. It waits for a stable clock lock, pulses the IDELAYCTRL
// reset, waits for calibration and then releases the design-wide sys_rst.
// The sequence re-runs on loss of lock, loss of IDELAY calibration, or a
// software reset pulse.
//
// Optional build macro: RESET_SEQ_LOCK_LOSS_CNT_EN
//   defined   -> lock_loss_count counts 1->0 edges of the synchronized lock
//                and saturates at 255
//   undefined -> lock_loss_count is tied to zero and no counter is built
module roach_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_SETTLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int RDY_TIMEOUT        = 4096,
    parameter int RELEASE_CYCLES     = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       sys_clk_lock,
    input  logic       idelay_rdy,
    input  logic       sw_rst,
    output logic       idelay_rst,
    output logic       sys_rst,
    output logic       seq_ready,
    output logic [2:0] seq_state,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        IDLY_RST  = 3'd2,
        WAIT_RDY  = 3'd3,
        RELEASE   = 3'd4,
        RUN       = 3'd5
    } state_e;

    // Terminal counts: a timed state of length N exits when the counter hits N-1.
    localparam logic [15:0] SETTLE_LAST  = 16'(LOCK_SETTLE_CYCLES - 1);
    localparam logic [15:0] IRST_LAST    = 16'(IDELAY_RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(RDY_TIMEOUT - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_CYCLES - 1);

    // Kept as a plain vector so that the illegal encodings 6 and 7 are representable.
    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [15:0]            cnt;
    logic                   timeout;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic                   lock_s;
    logic                   rdy_s;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign lock_s    = lock_sync[SYNC_STAGES-1];
    assign rdy_s     = rdy_sync[SYNC_STAGES-1];
    assign seq_state = state;

    // Bring the asynchronous lock and ready inputs into the sys_clk domain.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_sync <= '0;
            rdy_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], sys_clk_lock};
            rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], idelay_rdy};
        end
    end

    // Next-state decode; loss of lock overrides every other condition.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        if (state != WAIT_LOCK && !lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (lock_s) state_nxt = SETTLE;
                SETTLE:    if (cnt == SETTLE_LAST) state_nxt = IDLY_RST;
                IDLY_RST:  if (cnt == IRST_LAST) state_nxt = WAIT_RDY;
                WAIT_RDY: begin
                    if (rdy_s) begin
                        state_nxt = RELEASE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state_nxt = IDLY_RST;
                        timeout   = 1'b1;
                    end
                end
                RELEASE:   if (cnt == RELEASE_LAST) state_nxt = RUN;
                RUN: begin
                    if (!rdy_s) begin
                        state_nxt = IDLY_RST;
                    end else if (sw_rst) begin
                        state_nxt = RELEASE;
                    end
                end
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // State, shared timer and Moore outputs registered from the next state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            idelay_rst  <= 1'b1;
            sys_rst     <= 1'b1;
            seq_ready   <= 1'b0;
            retry_count <= '0;
        end else begin
            state      <= state_nxt;
            // Every transition lands in a different state, so a state change is an entry.
            cnt        <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            idelay_rst <= (state_nxt == WAIT_LOCK) || (state_nxt == SETTLE) ||
                          (state_nxt == IDLY_RST);
            sys_rst    <= (state_nxt != RUN);
            seq_ready  <= (state_nxt == RUN);
            if (timeout) begin
                retry_count <= sat_inc4(retry_count);
            end
        end
    end

`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    logic       lock_s_d;
    logic [7:0] lock_loss_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count falling edges of the synchronized lock; cleared only by sys_rst_n.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_s_d    <= 1'b0;
            lock_loss_q <= '0;
        end else begin
            lock_s_d <= lock_s;
            if (lock_s_d && !lock_s) begin
                lock_loss_q <= sat_inc8(lock_loss_q);
            end
        end
    end

    assign lock_loss_count = lock_loss_q;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_roach_reset_sequencer.sv
// Directed testbench for roach_reset_sequencer with short timing parameters.
module tb_roach_reset_sequencer;

    localparam int SS  = 2;
    localparam int LSC = 8;
    localparam int IRC = 4;
    localparam int RTO = 16;
    localparam int RC  = 3;
`ifdef RESET_SEQ_LOCK_LOSS_CNT_EN
    localparam int LL_EN = 1;
`else
    localparam int LL_EN = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       sys_clk_lock = 1'b0;
    logic       idelay_rdy = 1'b0;
    logic       sw_rst = 1'b0;
    logic       idelay_rst;
    logic       sys_rst;
    logic       seq_ready;
    logic [2:0] seq_state;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    // IDELAYCTRL model controls
    logic rdy_auto = 1'b1;
    logic rdy_man  = 1'b0;
    logic rdy_model = 1'b0;
    int   low_cnt = 0;

    int errors = 0;
    int checks = 0;

    roach_reset_sequencer #(
        .SYNC_STAGES       (SS),
        .LOCK_SETTLE_CYCLES(LSC),
        .IDELAY_RST_CYCLES (IRC),
        .RDY_TIMEOUT       (RTO),
        .RELEASE_CYCLES    (RC)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .sys_clk_lock   (sys_clk_lock),
        .idelay_rdy     (idelay_rdy),
        .sw_rst         (sw_rst),
        .idelay_rst     (idelay_rst),
        .sys_rst        (sys_rst),
        .seq_ready      (seq_ready),
        .seq_state      (seq_state),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Ready drops while idelay_rst is high, returns 5 cycles after it falls.
    always @(negedge sys_clk) begin
        if (idelay_rst) begin
            low_cnt   = 0;
            rdy_model = 1'b0;
        end else if (low_cnt < 5) begin
            low_cnt = low_cnt + 1;
            if (low_cnt == 5) rdy_model = 1'b1;
        end
        idelay_rdy = rdy_auto ? rdy_model : rdy_man;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int reached);
        reached = 0;
        for (int i = 0; i < max; i++) begin
            if (seq_state == s) begin
                reached = 1;
                break;
            end
            tick();
        end
        if (seq_state == s) reached = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, st2, irst_len, cnt, bad, reached, n_to, wr_len;
        logic [2:0] prev;

        // Reset values
        repeat (3) tick();
        check_val("rst_idelay_rst", idelay_rst, 1);
        check_val("rst_sys_rst", sys_rst, 1);
        check_val("rst_seq_ready", seq_ready, 0);
        check_val("rst_state", seq_state, 0);
        check_val("rst_retry", retry_count, 0);
        check_val("rst_lock_loss", lock_loss_count, 0);
        sys_rst_n = 1'b1;
        repeat (4) tick();
        check_val("idle_wait_lock", seq_state, 0);

        // 1: power-up sequence latency
        sys_clk_lock = 1'b1;
        n = 0; st2 = 0; irst_len = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (seq_state == 3'd2) begin
                st2 = st2 + 1;
                if (idelay_rst) irst_len = irst_len + 1;
            end
            if (seq_ready) begin
                n = i;
                break;
            end
        end
        check_val("t1_latency", n, SS + 1 + LSC + IRC + (5 + SS) + RC);
        check_val("t1_idly_rst_len", st2, IRC);
        check_val("t1_idelay_rst_high", irst_len, IRC);
        check_val("t1_run_state", seq_state, 5);
        check_val("t1_sys_rst", sys_rst, 0);
        check_val("t1_idelay_rst_low", idelay_rst, 0);
        check_val("t1_retry", retry_count, 0);

        // 4: software reset pulse in RUN
        sw_rst = 1'b1;
        cnt = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                sw_rst = 1'b0;
                check_val("t4_release_state", seq_state, 4);
            end
            if (sys_rst) cnt = cnt + 1;
            if (idelay_rst) bad = bad + 1;
            if (seq_ready) break;
        end
        check_val("t4_sys_rst_len", cnt, RC);
        check_val("t4_idelay_rst_quiet", bad, 0);
        check_val("t4_back_run", seq_state, 5);

        // 3: one-cycle lock drop in RUN
        sys_clk_lock = 1'b0;
        tick();
        sys_clk_lock = 1'b1;
        tick();
        tick();
        check_val("t3_wait_lock", seq_state, 0);
        check_val("t3_sys_rst", sys_rst, 1);
        check_val("t3_lock_loss", lock_loss_count, LL_EN);
        wait_state(3'd5, 100, reached);
        check_val("t3_rerun", reached, 1);
        check_val("t3_seq_ready", seq_ready, 1);

        // 5a: ready arrives in the same cycle as the WAIT_RDY timeout
        rdy_auto = 1'b0;
        rdy_man  = 1'b0;
        wait_state(3'd3, 50, reached);
        check_val("t5a_wait_rdy", reached, 1);
        repeat (RTO - 3) tick();
        rdy_man = 1'b1;
        repeat (3) tick();
        check_val("t5a_release", seq_state, 4);
        check_val("t5a_retry", retry_count, 0);
        repeat (RC) tick();
        check_val("t5a_run", seq_state, 5);

        // 2: ready held low, repeated timeouts saturate retry_count
        rdy_man = 1'b0;
        wait_state(3'd2, 20, reached);
        check_val("t2_idly_rst", reached, 1);
        n_to = 0; wr_len = 0; bad = 0;
        prev = seq_state;
        for (int i = 0; i < 800 && n_to < 20; i++) begin
            tick();
            if (!sys_rst) bad = bad + 1;
            if (seq_state == 3'd3) wr_len = wr_len + 1;
            if (prev == 3'd3 && seq_state == 3'd2) begin
                n_to = n_to + 1;
                if (n_to == 1) check_val("t2_wait_rdy_len", wr_len, RTO);
                wr_len = 0;
                check_val($sformatf("t2_retry_%0d", n_to), retry_count, (n_to > 15) ? 15 : n_to);
            end
            prev = seq_state;
        end
        check_val("t2_timeouts", n_to, 20);
        check_val("t2_sys_rst_held", bad, 0);
        check_val("t2_retry_sat", retry_count, 15);

        // 5b: lock loss and sw_rst in the same cycle
        rdy_auto = 1'b1;
        wait_state(3'd5, 200, reached);
        check_val("t5b_run", reached, 1);
        sys_clk_lock = 1'b0;
        tick();
        tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check_val("t5b_lock_wins", seq_state, 0);
        check_val("t5b_sys_rst", sys_rst, 1);
        check_val("t5b_lock_loss", lock_loss_count, 2 * LL_EN);
        sys_clk_lock = 1'b1;

        // 6: async reset mid-sequence, then an illegal state
        wait_state(3'd4, 100, reached);
        check_val("t6_release", reached, 1);
        sys_rst_n = 1'b0;
        sys_clk_lock = 1'b0;
        #1;
        check_val("t6_idelay_rst", idelay_rst, 1);
        check_val("t6_sys_rst", sys_rst, 1);
        check_val("t6_seq_ready", seq_ready, 0);
        check_val("t6_state", seq_state, 0);
        check_val("t6_retry", retry_count, 0);
        check_val("t6_lock_loss", lock_loss_count, 0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
        check_val("t6_post_rst", seq_state, 0);
        force dut.state = 3'd7;
        #1;
        check_val("t6_forced", seq_state, 7);
        tick();
        release dut.state;
        tick();
        check_val("t6_illegal_recover", seq_state, 0);
        check_val("t6_illegal_sys_rst", sys_rst, 1);
        check_val("t6_illegal_idelay_rst", idelay_rst, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
